// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 iterative multiply/divide unit for the RV64M
// MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ops. It sits beside the EX-stage ALU.
// The unit works on operand magnitudes, one shift-add or restoring-divide step per
// cycle. The sign fixup is folded into the last iteration edge. Divide-by-zero and
// signed overflow skip the iteration and go straight to DONE.
//
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   in_valid/ready   request handshake (ready only in IDLE)
//   in_op            funct3 (000 MUL .. 111 REMU)
//   in_a, in_b       rs1 / rs2 operands
//   in_tag           sideband returned on out_tag
//   out_valid/ready  result handshake (valid only in DONE)
//   out_result       result, held stable until taken
//   out_tag          tag of the accepted op
//   out_zero         out_result == 0
//   flush            present only with `ALU_MULDIV_FLUSH_EN: drops the op / result
//
// Optional feature macro: ALU_MULDIV_FLUSH_EN
module alu_muldiv_iter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero
`ifdef ALU_MULDIV_FLUSH_EN
  ,
  input  logic              flush
`endif
);
  localparam int W     = DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc;    // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [W-1:0]     mcand;  // |multiplicand| or |divisor|
  logic [2:0]       op_q;
  logic             neg_q;  // negate the final result

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_zero  = (out_result == '0);

  // Accept-side decode: signedness per operand, magnitudes, result sign, special cases.
  logic         is_div, sa, sb, a_neg, b_neg, neg_c, div0, ovf;
  logic [W-1:0] abs_a, abs_b;

  always_comb begin
    is_div = in_op[2];
    sa     = is_div ? ~in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
    sb     = is_div ? ~in_op[0] : (in_op[1:0] == 2'b01);
    a_neg  = sa & in_a[W-1];
    b_neg  = sb & in_b[W-1];
    abs_a  = a_neg ? -in_a : in_a;
    abs_b  = b_neg ? -in_b : in_b;
    // remainder follows the dividend; quotient and products follow the sign xor
    neg_c  = (is_div && in_op[1]) ? a_neg : (a_neg ^ b_neg);
    div0   = is_div && (in_b == '0);
    ovf    = is_div && !in_op[0] && (in_a == MIN) && (in_b == '1);
  end

  // One iteration step plus the fixup applied on the last step.
  logic [W:0]     sum, trial;
  logic [2*W-1:0] mul_nxt, div_nxt, nxt, nxt_neg;
  logic [W-1:0]   fix;

  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_nxt = {sum, acc[W-1:1]};
    // shifted remainder is {acc[2W-1:W-1]}, W+1 bits; a clear borrow means the step fits
    trial   = acc[2*W-1:W-1] - {1'b0, mcand};
    div_nxt = trial[W] ? {acc[2*W-2:0], 1'b0} : {trial[W-1:0], acc[W-2:0], 1'b1};
    nxt     = op_q[2] ? div_nxt : mul_nxt;
    nxt_neg = -nxt;
    fix     = '0;
    case (op_q)
      3'b000:         fix = neg_q ? nxt_neg[W-1:0] : nxt[W-1:0];
      3'b001, 3'b010: fix = neg_q ? nxt_neg[2*W-1:W] : nxt[2*W-1:W];
      3'b011:         fix = nxt[2*W-1:W];
      3'b100, 3'b101: fix = neg_q ? -nxt[W-1:0] : nxt[W-1:0];
      default:        fix = neg_q ? -nxt[2*W-1:W] : nxt[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end
`ifdef ALU_MULDIV_FLUSH_EN
    else if (flush) begin
      state <= IDLE;
    end
`endif
    else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q    <= in_op;
          neg_q   <= neg_c;
          out_tag <= in_tag;
          cnt     <= '0;
          if (div0) begin
            out_result <= in_op[1] ? in_a : '1;
            state      <= DONE;
          end else if (ovf) begin
            out_result <= in_op[1] ? '0 : MIN;
            state      <= DONE;
          end else begin
            acc   <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
            mcand <= is_div ? abs_b : abs_a;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            out_result <= fix;
            state      <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
